// File: rtl/seq_shift_mul.sv
// Sequential signed shift-and-add multiplier: one multiplier bit per CLK_DIV clocks, LSB first.
// Optional zero-operand bypass is enabled by defining SEQ_SHIFT_MUL_ZERO_SKIP_EN.
module seq_shift_mul #(
  parameter int N       = 41,
  parameter int CLK_DIV = 50
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_strb_i,
  input  logic [N-1:0]     a_i,
  input  logic [N-1:0]     b_i,
  output logic             done_strb_o,
  output logic             busy_o,
  output logic [2*N-1:0]   out_o
);

  localparam int W  = 2 * N;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = $clog2(N);

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE   = DW'(1);
  localparam logic [DW-1:0] DIV_ZERO  = DW'(0);
  localparam logic [SW-1:0] STEP_LAST = SW'(N - 1);
  localparam logic [SW-1:0] STEP_ONE  = SW'(1);
  localparam logic [SW-1:0] STEP_ZERO = SW'(0);
  localparam logic [W-1:0]  W_ZERO    = W'(0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q,  state_d;
  logic [DW-1:0] div_q,    div_d;
  logic [SW-1:0] step_q,   step_d;
  logic [W-1:0]  mcand_q,  mcand_d;
  logic [N-1:0]  mplier_q, mplier_d;
  logic [W-1:0]  acc_q,    acc_d;
  logic [W-1:0]  out_q,    out_d;
  logic          done_q,   done_d;
  logic          busy_q,   busy_d;
  logic [W-1:0]  acc_next_s;
`ifdef SEQ_SHIFT_MUL_ZERO_SKIP_EN
  logic          zero_q,   zero_d;
`endif

  // The sign bit of a two's complement multiplier carries weight -2^(N-1), so its
  // partial product is subtracted; all lower bits add.
  function automatic logic [W-1:0] partial_step(
    input logic [W-1:0] acc,
    input logic [W-1:0] mcand,
    input logic         bit_v,
    input logic         sign_bit
  );
    logic [W-1:0] res;
    if (!bit_v) begin
      res = acc;
    end else if (sign_bit) begin
      res = acc - mcand;
    end else begin
      res = acc + mcand;
    end
    return res;
  endfunction

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    step_d     = step_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    out_d      = out_q;
    acc_next_s = partial_step(acc_q, mcand_q, mplier_q[0], (step_q == STEP_LAST));
`ifdef SEQ_SHIFT_MUL_ZERO_SKIP_EN
    zero_d     = zero_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start_strb_i) begin
          state_d  = RUN;
          div_d    = DIV_ZERO;
          step_d   = STEP_ZERO;
          mcand_d  = {{N{a_i[N-1]}}, a_i};
          mplier_d = b_i;
          acc_d    = W_ZERO;
`ifdef SEQ_SHIFT_MUL_ZERO_SKIP_EN
          zero_d   = (a_i == {N{1'b0}}) || (b_i == {N{1'b0}});
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
`ifdef SEQ_SHIFT_MUL_ZERO_SKIP_EN
        if (zero_q) begin
          out_d   = W_ZERO;
          state_d = DONE;
        end else begin
`endif
          if (div_q == DIV_LAST) begin
            div_d    = DIV_ZERO;
            acc_d    = acc_next_s;
            mcand_d  = {mcand_q[W-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[N-1:1]};
            step_d   = step_q + STEP_ONE;
            if (step_q == STEP_LAST) begin
              out_d   = acc_next_s;
              state_d = DONE;
            end else begin
              state_d = RUN;
            end
          end else begin
            div_d = div_q + DIV_ONE;
          end
`ifdef SEQ_SHIFT_MUL_ZERO_SKIP_EN
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    done_d = (state_d == DONE);
    busy_d = (state_d == RUN);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      div_q    <= DIV_ZERO;
      step_q   <= STEP_ZERO;
      mcand_q  <= W_ZERO;
      mplier_q <= {N{1'b0}};
      acc_q    <= W_ZERO;
      out_q    <= W_ZERO;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef SEQ_SHIFT_MUL_ZERO_SKIP_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      step_q   <= step_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
`ifdef SEQ_SHIFT_MUL_ZERO_SKIP_EN
      zero_q   <= zero_d;
`endif
    end
  end

  assign out_o       = out_q;
  assign done_strb_o = done_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_seq_shift_mul.sv
// Scoreboard bench for seq_shift_mul (N=8, CLK_DIV=3): directed vectors, decoupled monitor.
module tb_seq_shift_mul;

  localparam int N        = 8;
  localparam int CD       = 3;
  localparam int LAT_FULL = N * CD;
`ifdef SEQ_SHIFT_MUL_ZERO_SKIP_EN
  localparam int LAT_ZERO = 1;
`else
  localparam int LAT_ZERO = LAT_FULL;
`endif

  logic          clk = 1'b0;
  logic          rst_i;
  logic          start_strb_i;
  logic [N-1:0]  a_i;
  logic [N-1:0]  b_i;
  logic          done_strb_o;
  logic          busy_o;
  logic [2*N-1:0] out_o;

  typedef struct {
    logic [15:0] prod;
    int          cyc;
    int          blen;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   busy_cnt = 0;

  seq_shift_mul #(.N(N), .CLK_DIV(CD)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_strb_i (start_strb_i),
    .a_i          (a_i),
    .b_i          (b_i),
    .done_strb_o  (done_strb_o),
    .busy_o       (busy_o),
    .out_o        (out_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every done strobe and tracks the busy run length.
  initial begin
    forever begin
      @(negedge clk);
      if (done_strb_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("product", {16'd0, out_o}, {16'd0, mon_e.prod});
          check("done_cycle", cyc, mon_e.cyc);
          check("busy_len", busy_cnt, mon_e.blen);
        end
        busy_cnt = 0;
      end else if (busy_o === 1'b1) begin
        busy_cnt = busy_cnt + 1;
      end else begin
        busy_cnt = 0;
      end
    end
  end

  // Called at a negedge; the start is sampled at the following edge k.
  task automatic drive(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] ev,
                       input int lat, input bit push);
    exp_t e;
    start_strb_i = 1'b1;
    a_i = av;
    b_i = bv;
    if (push) begin
      e.prod = ev;
      e.cyc  = cyc + 1 + lat;
      e.blen = lat;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start_strb_i = 1'b0;
    a_i = 8'h5A;
    b_i = 8'hA5;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && busy_o == 1'b0) return;
      @(negedge clk);
    end
    check("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    rst_i = 1'b1;
    start_strb_i = 1'b0;
    a_i = 8'd0;
    b_i = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_out", {16'd0, out_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_strb_o}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk);

    drive(8'd7, 8'hFB, 16'hFFDD, LAT_FULL, 1'b1);   wait_idle();
    drive(8'h80, 8'h80, 16'h4000, LAT_FULL, 1'b1);  wait_idle();
    drive(8'h80, 8'h7F, 16'hC080, LAT_FULL, 1'b1);  wait_idle();
    drive(8'h7F, 8'h7F, 16'h3F01, LAT_FULL, 1'b1);  wait_idle();
    drive(8'hFF, 8'hFF, 16'h0001, LAT_FULL, 1'b1);  wait_idle();

    // A second start while running must be ignored.
    drive(8'd3, 8'd4, 16'd12, LAT_FULL, 1'b1);
    repeat (4) @(negedge clk);
    drive(8'd9, 8'd9, 16'd0, LAT_FULL, 1'b0);
    wait_idle();
    repeat (30) @(negedge clk);
    check("out_hold", {16'd0, out_o}, 32'd12);

    // Start presented during the DONE cycle is accepted with no idle gap.
    drive(8'd5, 8'hFD, 16'hFFF1, LAT_FULL, 1'b1);
    for (int i = 0; i < 100 && done_strb_o !== 1'b1; i++) @(negedge clk);
    check("b2b_done_seen", {31'd0, done_strb_o}, 32'd1);
    drive(8'hFE, 8'd6, 16'hFFF4, LAT_FULL, 1'b1);
    wait_idle();

    // Reset mid-operation aborts with no done strobe.
    drive(8'd7, 8'd7, 16'd0, LAT_FULL, 1'b0);
    repeat (12) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("abort_out", {16'd0, out_o}, 32'd0);
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    check("abort_done", {31'd0, done_strb_o}, 32'd0);
    repeat (40) @(negedge clk);

    drive(8'd6, 8'd7, 16'd42, LAT_FULL, 1'b1);      wait_idle();
    drive(8'd0, 8'h37, 16'd0, LAT_ZERO, 1'b1);      wait_idle();
    drive(8'd6, 8'd7, 16'd42, LAT_FULL, 1'b1);      wait_idle();
    drive(8'hB3, 8'd0, 16'd0, LAT_ZERO, 1'b1);      wait_idle();
    repeat (5) @(negedge clk);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
